// File: rtl/seg_ser2para.sv
// -----------------------------------------------------------------------------
// seg_ser2para
//   Receiving end of the serial 7-segment display link. The link inputs are
//   oversampled with clk, the serial frame is rebuilt in a shift register and
//   committed on the rising edge of seg_en. The three low bytes of a committed
//   frame are decoded from active-low segment patterns back into a BCD score.
//
// Ports
//   clk          in   1          system clock, rising edge
//   rst          in   1          asynchronous reset, active low
//   seg_clk      in   1          link shift clock (seg_dt sampled on its rise)
//   seg_clr      in   1          link clear, active low, aborts a frame
//   seg_dt       in   1          link serial data, MSB first
//   seg_en       in   1          link latch strobe, rise commits the frame
//   frame        out  FRAME_BITS last committed frame, MSB = first bit received
//   frame_valid  out  1          one-cycle pulse when frame/score update
//   score        out  12         BCD {hundreds,tens,ones} from frame[23:0]
//   digit_err    out  1          a digit byte of the last commit had no decode
//   frame_err    out  1          one-cycle pulse: wrong bit count at seg_en
// -----------------------------------------------------------------------------
module seg_ser2para #(
   parameter int FRAME_BITS  = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  seg_clk,
   input  logic                  seg_clr,
   input  logic                  seg_dt,
   input  logic                  seg_en,
   output logic [FRAME_BITS-1:0] frame,
   output logic                  frame_valid,
   output logic [11:0]           score,
   output logic                  digit_err,
   output logic                  frame_err
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT,
      ERR
   } state_t;

   localparam logic [6:0] FB_CNT  = 7'(FRAME_BITS);
   localparam logic [6:0] CNT_MAX = 7'h7f;

   // Index SYNC_STAGES-1 is the synchronized value, index SYNC_STAGES the
   // history flop used for edge detection.
   logic [SYNC_STAGES:0]  clk_p;
   logic [SYNC_STAGES:0]  clr_p;
   logic [SYNC_STAGES:0]  dt_p;
   logic [SYNC_STAGES:0]  en_p;

   state_t                state;
   logic [6:0]            cnt;
   logic [FRAME_BITS-1:0] sr;

   logic                  clk_rise;
   logic                  en_rise;
   logic                  clr_act;
   logic                  dt_s;
   logic [6:0]            cnt_nxt;
   logic [4:0]            dec_h;
   logic [4:0]            dec_t;
   logic [4:0]            dec_o;

   // Active-low segment byte to {no_match, bcd_nibble}.
   function automatic logic [4:0] seg_decode(input logic [7:0] b);
      logic [4:0] r;
      case (b)
         8'hC0:   r = 5'h00;
         8'hF9:   r = 5'h01;
         8'hA4:   r = 5'h02;
         8'hB0:   r = 5'h03;
         8'h99:   r = 5'h04;
         8'h92:   r = 5'h05;
         8'h82:   r = 5'h06;
         8'hF8:   r = 5'h07;
         8'h80:   r = 5'h08;
         8'h90:   r = 5'h09;
         default: r = 5'h1F;
      endcase
      return r;
   endfunction

   always_comb begin
      clk_rise = clk_p[SYNC_STAGES-1] & ~clk_p[SYNC_STAGES];
      en_rise  = en_p[SYNC_STAGES-1]  & ~en_p[SYNC_STAGES];
      clr_act  = ~clr_p[SYNC_STAGES-1];
      dt_s     = dt_p[SYNC_STAGES-1];

      // Count after this cycle's shift; a coincident seg_en rise is judged
      // against this updated value. Saturates instead of wrapping.
      cnt_nxt = cnt;
      if (clk_rise && (cnt != CNT_MAX))
         cnt_nxt = cnt + 7'd1;

      dec_h = seg_decode(sr[23:16]);
      dec_t = seg_decode(sr[15:8]);
      dec_o = seg_decode(sr[7:0]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_p       <= '0;
         clr_p       <= '0;
         dt_p        <= '0;
         en_p        <= '0;
         state       <= IDLE;
         cnt         <= '0;
         sr          <= '0;
         frame       <= '0;
         score       <= '0;
         digit_err   <= 1'b0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         clk_p <= {clk_p[SYNC_STAGES-1:0], seg_clk};
         clr_p <= {clr_p[SYNC_STAGES-1:0], seg_clr};
         dt_p  <= {dt_p[SYNC_STAGES-1:0],  seg_dt};
         en_p  <= {en_p[SYNC_STAGES-1:0],  seg_en};

         frame_valid <= 1'b0;
         frame_err   <= 1'b0;

         if (clr_act) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               // cnt is always 0 in IDLE, so IDLE and SHIFT share one rule set.
               IDLE, SHIFT: begin
                  if (clk_rise) begin
                     sr  <= {sr[FRAME_BITS-2:0], dt_s};
                     cnt <= cnt_nxt;
                  end
                  if (en_rise)
                     state <= (cnt_nxt == FB_CNT) ? COMMIT : ERR;
                  else if (clk_rise)
                     state <= SHIFT;
               end
               COMMIT: begin
                  frame       <= sr;
                  score       <= {dec_h[3:0], dec_t[3:0], dec_o[3:0]};
                  digit_err   <= dec_h[4] | dec_t[4] | dec_o[4];
                  frame_valid <= 1'b1;
                  cnt         <= '0;
                  state       <= IDLE;
               end
               ERR: begin
                  frame_err <= 1'b1;
                  cnt       <= '0;
                  state     <= IDLE;
               end
               default: begin
                  cnt   <= '0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seg_ser2para.sv
module tb_seg_ser2para;

   logic        clk = 1'b0;
   logic        rst;
   logic        seg_clk, seg_clr, seg_dt, seg_en;
   logic [63:0] frame;
   logic        frame_valid;
   logic [11:0] score;
   logic        digit_err;
   logic        frame_err;

   int unsigned checks = 0;
   int unsigned errors = 0;

   seg_ser2para #(.FRAME_BITS(64), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_clk     (seg_clk),
      .seg_clr     (seg_clr),
      .seg_dt      (seg_dt),
      .seg_en      (seg_en),
      .frame       (frame),
      .frame_valid (frame_valid),
      .score       (score),
      .digit_err   (digit_err),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   // Reference model: value of each segment code is its position in this list.
   logic [7:0] codes [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   logic [63:0] m_frame;
   logic [11:0] m_score;
   logic        m_derr;

   // Returns {digit_err, score} for a committed frame.
   function automatic logic [12:0] ref_score(input logic [63:0] d);
      logic [11:0] s = '0;
      logic        e = 1'b0;
      for (int j = 0; j < 3; j++) begin
         logic [7:0] b = d[8*j +: 8];
         int         v = 15;
         for (int c = 0; c < 10; c++)
            if (codes[c] == b) v = c;
         if (v == 15) e = 1'b1;
         s[4*j +: 4] = 4'(v);
      end
      return {e, s};
   endfunction

   typedef struct {
      logic [63:0] d;
      int          n;
      bit          commit;
      logic [63:0] ef;
      logic [11:0] es;
      logic        ed;
   } vec_t;

   vec_t vt [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      seg_dt = b;
      repeat (2) @(negedge clk);
      seg_clk = 1'b1;
      repeat (3) @(negedge clk);
      seg_clk = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Bits beyond 64 are sent as 0. same_edge raises the last seg_clk
   // together with seg_en.
   task automatic run_frame(input string tag, input logic [63:0] d, input int n,
                            input bit same_edge, input bit commit,
                            input logic [63:0] ef, input logic [11:0] es, input logic ed);
      logic [7:0] vp = '0;
      logic [7:0] ep = '0;
      int nshift = same_edge ? n - 1 : n;
      for (int i = 0; i < nshift; i++)
         send_bit((i < 64) ? d[63-i] : 1'b0);
      if (same_edge) begin
         seg_dt = (nshift < 64) ? d[63-nshift] : 1'b0;
         repeat (2) @(negedge clk);
         seg_clk = 1'b1;
      end
      seg_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         vp[k] = frame_valid;
         ep[k] = frame_err;
      end
      chk({tag, "_valid_pulse"}, 64'(vp), commit ? 64'h08 : 64'h00);
      chk({tag, "_err_pulse"},   64'(ep), commit ? 64'h00 : 64'h08);
      chk({tag, "_frame"},       frame, ef);
      chk({tag, "_score"},       64'(score), 64'(es));
      chk({tag, "_digit_err"},   64'(digit_err), 64'(ed));
      @(negedge clk);
      seg_en  = 1'b0;
      seg_clk = 1'b0;
      repeat (4) @(negedge clk);
      m_frame = ef;
      m_score = es;
      m_derr  = ed;
   endtask

   task automatic run_model(input string tag, input logic [63:0] d, input int n, input bit same_edge);
      logic [12:0] r = ref_score(d);
      if (n == 64)
         run_frame(tag, d, n, same_edge, 1'b1, d, r[11:0], r[12]);
      else
         run_frame(tag, d, n, same_edge, 1'b0, m_frame, m_score, m_derr);
   endtask

   initial begin
      logic [63:0] d;
      logic [7:0]  pulses;
      int          n;

      vt[0] = '{64'h92C6C08886F9A4B0, 64, 1'b1, 64'h92C6C08886F9A4B0, 12'h123, 1'b0};
      vt[1] = '{64'h0123456789C0C0C0, 64, 1'b1, 64'h0123456789C0C0C0, 12'h000, 1'b0};
      vt[2] = '{64'hFEDCBA9876909090, 64, 1'b1, 64'hFEDCBA9876909090, 12'h999, 1'b0};
      vt[3] = '{64'hAAAAAAAAAAAAAAAA, 63, 1'b0, 64'hFEDCBA9876909090, 12'h999, 1'b0};
      vt[4] = '{64'h5555555555555555, 65, 1'b0, 64'hFEDCBA9876909090, 12'h999, 1'b0};
      vt[5] = '{64'h1111111111F9A4FF, 64, 1'b1, 64'h1111111111F9A4FF, 12'h12F, 1'b1};
      vt[6] = '{64'h2222222222C0F9A4, 64, 1'b1, 64'h2222222222C0F9A4, 12'h012, 1'b0};
      vt[7] = '{64'h0000000000000000, 0,  1'b0, 64'h2222222222C0F9A4, 12'h012, 1'b0};

      rst = 1'b0; seg_clk = 1'b0; seg_clr = 1'b1; seg_dt = 1'b0; seg_en = 1'b0;
      m_frame = '0; m_score = '0; m_derr = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_frame", frame, 64'h0);
      chk("reset_flags", 64'({score, digit_err, frame_valid, frame_err}), 64'h0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 8; i++)
         run_frame($sformatf("vec%0d", i), vt[i].d, vt[i].n, 1'b0,
                   vt[i].commit, vt[i].ef, vt[i].es, vt[i].ed);

      // Last shift clock and latch strobe rise together.
      run_frame("same_edge", 64'h3333333333B09982, 64, 1'b1, 1'b1,
                64'h3333333333B09982, 12'h346, 1'b0);

      // Clear aborts a partial frame without touching outputs.
      d = 64'hDEADBEEFCAFEF00D;
      for (int i = 0; i < 30; i++) send_bit(d[63-i]);
      pulses = '0;
      seg_clr = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         pulses[k] = frame_valid | frame_err;
      end
      @(negedge clk);
      seg_clr = 1'b1;
      repeat (4) @(negedge clk);
      chk("clr_no_pulse", 64'(pulses), 64'h0);
      chk("clr_frame_hold", frame, m_frame);
      chk("clr_score_hold", 64'(score), 64'(m_score));
      run_frame("after_clr", 64'h4444444444F8F880, 64, 1'b0, 1'b1,
                64'h4444444444F8F880, 12'h778, 1'b0);

      for (int r = 0; r < 12; r++) begin
         d = {$urandom, $urandom};
         for (int j = 0; j < 3; j++)
            if ($urandom_range(0, 3) != 0)
               d[8*j +: 8] = codes[$urandom_range(0, 9)];
         n = 64;
         if ($urandom_range(0, 3) == 0) n = 62 + 2 * int'($urandom_range(0, 2)) - ($urandom_range(0, 1) == 1 ? 1 : 0);
         run_model($sformatf("rand%0d", r), d, n, $urandom_range(0, 3) == 0);
      end

      // Asynchronous reset in the middle of a frame.
      d = 64'h0F0F0F0F0F0F0F0F;
      for (int i = 0; i < 40; i++) send_bit(d[63-i]);
      rst = 1'b0;
      #1;
      chk("rst_mid_frame", frame, 64'h0);
      chk("rst_mid_flags", 64'({score, digit_err, frame_valid, frame_err}), 64'h0);
      m_frame = '0; m_score = '0; m_derr = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      run_model("after_rst", 64'h5555555555929290, 64, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
